// File: rtl/apb_arb_pkg.sv
// Shared constants and FSM encoding for the APB master arbiter.
package apb_arb_pkg;

  localparam int unsigned DEF_APB_ADDR_WIDTH = 32;
  localparam int unsigned DEF_APB_DATA_WIDTH = 32;
  localparam int unsigned DEF_REQ_NUM        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLE  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester-side and APB-side bus of the arbiter; master = arbiter view, slave = environment view.
interface apb_master_arb_if
  import apb_arb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
  parameter int unsigned APB_DATA_WIDTH = DEF_APB_DATA_WIDTH,
  parameter int unsigned REQ_NUM        = DEF_REQ_NUM
);

  logic [REQ_NUM-1:0]                req_valid_in;
  logic [REQ_NUM*APB_ADDR_WIDTH-1:0] req_addr_in;
  logic [REQ_NUM-1:0]                req_write_in;
  logic [REQ_NUM*APB_DATA_WIDTH-1:0] req_wdata_in;
  logic [REQ_NUM-1:0]                req_gnt_out;
  logic [REQ_NUM-1:0]                req_done_out;
  logic [APB_DATA_WIDTH-1:0]         req_rdata_out;
  logic                              req_error_out;

  logic [APB_ADDR_WIDTH-1:0]         apb_addr_out;
  logic                              apb_write_out;
  logic [APB_DATA_WIDTH-1:0]         apb_wdata_out;
  logic                              apb_psel_out;
  logic                              apb_penable_out;
  logic [APB_DATA_WIDTH-1:0]         apb_rdata_in;
  logic                              apb_ready_in;
  logic                              apb_slverr_in;

  modport master (
    input  req_valid_in, req_addr_in, req_write_in, req_wdata_in,
    input  apb_rdata_in, apb_ready_in, apb_slverr_in,
    output req_gnt_out, req_done_out, req_rdata_out, req_error_out,
    output apb_addr_out, apb_write_out, apb_wdata_out, apb_psel_out, apb_penable_out
  );

  modport slave (
    output req_valid_in, req_addr_in, req_write_in, req_wdata_in,
    output apb_rdata_in, apb_ready_in, apb_slverr_in,
    input  req_gnt_out, req_done_out, req_rdata_out, req_error_out,
    input  apb_addr_out, apb_write_out, apb_wdata_out, apb_psel_out, apb_penable_out
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last winner and wraps.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = DEF_REQ_NUM
) (
  input  logic [REQ_NUM-1:0]            i_req,
  input  logic [idx_width(REQ_NUM)-1:0] i_last,
  output logic [REQ_NUM-1:0]            o_gnt,
  output logic [idx_width(REQ_NUM)-1:0] o_idx,
  output logic                          o_any
);

  localparam int unsigned IDX_W = idx_width(REQ_NUM);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int off = 1; off <= int'(REQ_NUM); off++) begin
      w_cand = IDX_W'((int'(i_last) + off) % int'(REQ_NUM));
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master shared by REQ_NUM requesters; IDLE/SETUP/ACCESS FSM with registered outputs.
// Optional ACCESS timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
  parameter int unsigned APB_DATA_WIDTH = DEF_APB_DATA_WIDTH,
  parameter int unsigned REQ_NUM        = DEF_REQ_NUM,
  parameter int unsigned TIMEOUT_CYCLE  = DEF_TIMEOUT_CYCLE
) (
  input  logic          apb_clk_in,
  input  logic          apb_rstn_in,
  apb_master_arb_if.master bus
);

  localparam int unsigned IDX_W = idx_width(REQ_NUM);

  apb_state_t                r_state;
  logic [IDX_W-1:0]          r_last;
  logic [REQ_NUM-1:0]        r_gnt;
  logic [REQ_NUM-1:0]        r_done;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_error;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_psel;
  logic                      r_penable;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLE + 1);
  logic [TMO_W-1:0]          r_tmo_cnt;
`endif

  logic [REQ_NUM-1:0]        w_gnt;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_any;

  apb_rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
    .i_req  (bus.req_valid_in),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_state   <= ST_IDLE;
      r_last    <= IDX_W'(REQ_NUM - 1);  // requester 0 wins first
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      // NOTE: state updates are non-blocking so every register samples pre-edge values.
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last  <= w_idx;
            r_gnt   <= w_gnt;
            r_addr  <= bus.req_addr_in[int'(w_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            r_write <= bus.req_write_in[w_idx];
            r_wdata <= bus.req_wdata_in[int'(w_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            r_psel  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.apb_ready_in) begin
            r_done    <= r_gnt;
            r_rdata   <= r_write ? '0 : bus.apb_rdata_in;
            r_error   <= bus.apb_slverr_in;
            r_gnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= ST_IDLE;
`ifdef APB_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLE - 1)) begin
            // Completer never answered: report an error to the owner and free the bus.
            r_done    <= r_gnt;
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_gnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= ST_IDLE;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_gnt_out     = r_gnt;
  assign bus.req_done_out    = r_done;
  assign bus.req_rdata_out   = r_rdata;
  assign bus.req_error_out   = r_error;
  assign bus.apb_addr_out    = r_addr;
  assign bus.apb_write_out   = r_write;
  assign bus.apb_wdata_out   = r_wdata;
  assign bus.apb_psel_out    = r_psel;
  assign bus.apb_penable_out = r_penable;

endmodule
